// File: rtl/sample_delay_buf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_delay_buf_pkg : FSM state type and default geometry for sample_delay_buf
// Option: SAMPLE_DELAY_BUF_CLEAR_EN adds the CLEAR state.  Rev 1.0
// ---------------------------------------------------------------------------
package sample_delay_buf_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
    ,
    ST_CLEAR = 2'd3
`endif
  } sdb_state_t;

endpackage
`default_nettype wire

// File: rtl/sdb_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdb_ram : 2**AW x DW storage, one write port, one read port with registered
// output. Contents are never reset; only the read register is.  Rev 1.0
// ---------------------------------------------------------------------------
module sdb_ram
  import sample_delay_buf_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sample_delay_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_delay_buf : delays an accepted sample stream by a programmable offset.
// Option: SAMPLE_DELAY_BUF_CLEAR_EN zero-fills the buffer before RUN.  Rev 1.0
// ---------------------------------------------------------------------------
module sample_delay_buf
  import sample_delay_buf_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] offset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          filled
);

  sdb_state_t    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_count;
  logic [AW-1:0] r_offset_q;
  logic          r_out_valid;
  logic          r_byp_sel;
  logic [DW-1:0] r_byp_data;

  logic          w_acc;
  logic          w_run_acc;
  logic [AW-1:0] w_count_nxt;
  logic [AW-1:0] w_rd_addr;
  logic [DW-1:0] w_ram_q;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  assign in_ready    = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign filled      = (r_state == ST_RUN);
  // en low discards an accept in the same cycle as the abort
  assign w_acc       = in_valid && in_ready && en;
  assign w_run_acc   = w_acc && (r_state == ST_RUN);
  assign w_count_nxt = r_count + AW'(1);
  assign w_rd_addr   = r_wr_ptr - r_offset_q;

`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
  logic [AW-1:0] r_clr_addr;
  logic          w_clearing;

  assign w_clearing = (r_state == ST_CLEAR) && en;
  assign w_we       = w_acc || w_clearing;
  assign w_waddr    = w_clearing ? r_clr_addr : r_wr_ptr;
  assign w_wdata    = w_clearing ? '0 : in_data;
`else
  assign w_we       = w_acc;
  assign w_waddr    = r_wr_ptr;
  assign w_wdata    = in_data;
`endif

  sdb_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_run_acc),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  // Zero offset reads the location being written, so take the input sample instead.
  assign out_data  = r_byp_sel ? r_byp_data : w_ram_q;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_offset_q  <= '0;
      r_out_valid <= 1'b0;
      r_byp_sel   <= 1'b0;
      r_byp_data  <= '0;
`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
      r_clr_addr  <= '0;
`endif
    end else begin
      r_out_valid <= w_run_acc;
      if (w_run_acc) begin
        r_byp_sel  <= (r_offset_q == '0);
        r_byp_data <= in_data;
      end
      if (!en) begin
        r_state  <= ST_IDLE;
        r_wr_ptr <= '0;
        r_count  <= '0;
`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
        r_clr_addr <= '0;
`endif
      end else begin
        if (w_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
        case (r_state)
          ST_IDLE: begin
            r_offset_q <= offset;
`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
            r_clr_addr <= '0;
            r_state    <= ST_CLEAR;
`else
            r_state    <= (offset != '0) ? ST_FILL : ST_RUN;
`endif
          end
          ST_FILL: begin
            if (w_acc) begin
              if (w_count_nxt == r_offset_q) begin
                r_state <= ST_RUN;
                r_count <= '0;
              end else begin
                r_count <= w_count_nxt;
              end
            end
          end
          ST_RUN: begin
            r_state <= ST_RUN;
          end
`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
          ST_CLEAR: begin
            r_clr_addr <= r_clr_addr + AW'(1);
            if (&r_clr_addr) r_state <= ST_RUN;
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_delay_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sample_delay_buf : directed and random stimulus against a session model
// of the delay buffer (AW=4, DW=8).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_sample_delay_buf;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [AW-1:0] offset = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          filled;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a session starts on the enable edge; accept k (0-based) of the
  // session yields sample k-offset, or nothing while k < offset.
  bit          m_active;
  int          m_off;
  int          m_k;
  int          m_clr;
  logic [7:0]  hist[$];
  bit          exp_ov;
  logic [7:0]  exp_od;
  logic [7:0]  outs[$];

  always #5 clk = ~clk;

  sample_delay_buf #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .offset    (offset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .filled    (filled)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_active && (m_clr == DEPTH);
  endfunction

  function automatic bit m_filled();
`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
    return m_ready();
`else
    return m_active && (m_k >= m_off);
`endif
  endfunction

  task automatic model_reset();
    m_active = 0; m_off = 0; m_k = 0; m_clr = 0;
    hist.delete();
    exp_ov = 0; exp_od = '0;
  endtask

  task automatic model_edge();
    bit acc;
    acc    = in_valid && m_ready() && en;
    exp_ov = 0;
    if (!en) begin
      m_active = 0; m_k = 0; hist.delete();
    end else if (!m_active) begin
      m_active = 1; m_off = int'(offset); m_k = 0; hist.delete();
`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
      m_clr = 0;
`else
      m_clr = DEPTH;
`endif
    end else if (m_clr < DEPTH) begin
      m_clr++;
    end else if (acc) begin
      hist.push_back(in_data);
      if (m_k >= m_off) begin
        exp_ov = 1; exp_od = hist[m_k - m_off];
      end else begin
`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
        exp_ov = 1; exp_od = '0;
`endif
      end
      m_k++;
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, exp_ov);
    chk("out_data", out_data, exp_od);
    chk("in_ready", in_ready, m_ready());
    chk("filled", filled, m_filled());
    if (out_valid) outs.push_back(out_data);
  endtask

  // Inputs change on the falling edge; DUT and model are compared on the next one.
  task automatic cycle(input bit e, input bit v, input int off, input bit rnd);
    en       = e;
    in_valid = v;
    offset   = AW'(off);
    in_data  = rnd ? DW'($urandom) : DW'(m_k + 1);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_filled", filled, 0);
    rst = 1'b0;

`ifdef SAMPLE_DELAY_BUF_CLEAR_EN
    cycle(1, 1, 3, 0);
    chk("clear_ready_low", in_ready, 0);
    repeat (15) begin
      cycle(1, 1, 3, 0);
      chk("clear_ready_low", in_ready, 0);
    end
    cycle(1, 1, 3, 0);
    chk("clear_ready_high", in_ready, 1);
    outs.delete();
    repeat (6) cycle(1, 1, 3, 0);
    chk("clear_out_count", outs.size(), 6);
    for (int i = 0; i < 6 && i < outs.size(); i++)
      chk("clear_out_data", outs[i], (i < 3) ? 0 : i - 2);
    cycle(0, 1, 3, 0);
`else
    // Basic delay, offset 3
    cycle(1, 1, 3, 0);
    cycle(1, 1, 3, 0);
    cycle(1, 1, 3, 0);
    chk("basic_not_filled", filled, 0);
    cycle(1, 1, 3, 0);
    chk("basic_filled_3rd", filled, 1);
    chk("basic_no_out_3rd", out_valid, 0);
    cycle(1, 1, 3, 0);
    chk("basic_first_valid", out_valid, 1);
    chk("basic_first_data", out_data, 1);
    cycle(1, 1, 3, 0);
    chk("basic_second_data", out_data, 2);
    cycle(1, 1, 3, 0);
    chk("basic_third_data", out_data, 3);
    cycle(0, 1, 3, 0);

    // Zero offset bypass
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("zero_first_valid", out_valid, 1);
    chk("zero_first_data", out_data, 1);
    cycle(1, 1, 0, 0);
    chk("zero_second_data", out_data, 2);
    cycle(0, 1, 0, 0);

    // Wrap, offset 15, 20 accepts
    outs.delete();
    cycle(1, 1, 15, 0);
    repeat (20) cycle(1, 1, 15, 0);
    chk("wrap_out_count", outs.size(), 5);
    for (int i = 0; i < 5 && i < outs.size(); i++)
      chk("wrap_out_data", outs[i], i + 1);
    cycle(0, 1, 15, 0);

    // Abort during FILL then re-enable
    cycle(1, 1, 5, 0);
    cycle(1, 1, 5, 0);
    cycle(1, 1, 5, 0);
    cycle(0, 1, 5, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_filled", filled, 0);
    outs.delete();
    cycle(1, 1, 2, 0);
    repeat (3) cycle(1, 1, 2, 0);
    chk("abort_new_valid", out_valid, 1);
    chk("abort_new_data", out_data, 1);
    chk("abort_new_count", outs.size(), 1);
    cycle(0, 1, 2, 0);
`endif

    // Asynchronous reset mid-RUN
    cycle(1, 1, 1, 0);
    repeat (4) cycle(1, 1, 1, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_filled", filled, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (24) cycle(1, 1, 2, 0);
    cycle(0, 1, 2, 0);

    // Random traffic
    repeat (600)
      cycle($urandom_range(0, 24) != 0, $urandom_range(0, 9) < 7,
            int'($urandom_range(0, 15)), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_delay_buf.md
SAMPLE_DELAY_BUF -- requirements
Module: sample_delay_buf

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning buffer address width (depth 2**AW).
REQ-002 The block SHALL have parameter DW, default 8, meaning sample width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, which is asynchronous and active-high.
REQ-005 The block SHALL have port en, input, 1, meaning run enable.
REQ-006 The block SHALL have port offset, input, AW, meaning delay in samples.
REQ-007 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DW), meaning the sample input handshake.
REQ-008 The block SHALL have ports out_valid (output, 1) and out_data (output, DW), meaning the delayed sample output.
REQ-009 The block SHALL have port filled, output, 1, meaning the block is in RUN.

Function
REQ-010 The FSM SHALL have states IDLE, FILL and RUN, plus CLEAR when the REQ-024 macro is defined.
REQ-011 An accept SHALL occur when in_valid and in_ready are both 1.
REQ-012 in_ready SHALL be 1 only in FILL or RUN.
REQ-013 On each accept, the block SHALL write in_data at wr_ptr, and wr_ptr SHALL then increment modulo 2**AW.
REQ-014 In IDLE with en=1, the block SHALL register offset into offset_q.
  - It SHALL go to FILL if offset_q != 0, otherwise to RUN.
  - Changes to offset outside IDLE SHALL be ignored.
REQ-015 In FILL, the block SHALL count accepts; the accept that makes the count equal to offset_q SHALL move the FSM to RUN on the same edge.
  - No output SHALL be produced for FILL accepts.
REQ-016 In RUN, each accept SHALL produce out_valid=1 for exactly one cycle, one cycle after the accept.
  - out_data SHALL equal the sample accepted offset_q accepts earlier.
  - The read address SHALL be (wr_ptr - offset_q) mod 2**AW.
REQ-017 When offset_q=0, out_data SHALL equal the in_data of the same accept, through a write-to-read bypass with no RAM read-during-write hazard.
REQ-018 out_valid SHALL be 0 in every cycle not covered by REQ-016.
  - out_data SHALL hold its last value when out_valid=0.
REQ-019 en=0 in any state SHALL take the FSM to IDLE on the next edge.
  - wr_ptr and the fill count SHALL clear to 0.
  - An accept in that same cycle SHALL be discarded: no write, no output.
REQ-020 filled SHALL equal (state == RUN).
REQ-021 Pointer wrap SHALL be silent; the block SHALL have no full/empty condition beyond FILL.

Reset
REQ-022 When rst=1, the block SHALL immediately set state=IDLE, wr_ptr=0, count=0, offset_q=0, in_ready=0, out_valid=0, out_data=0 and filled=0.
REQ-023 RAM contents SHALL NOT be reset; reset mid-RUN or mid-CLEAR SHALL abort the operation with no further outputs.

Configuration
REQ-024 The macro SAMPLE_DELAY_BUF_CLEAR_EN SHALL control the CLEAR behaviour.
  - Defined: IDLE->en=1 SHALL enter CLEAR, which writes 0 to all 2**AW locations, one per cycle, with in_ready=0, and then goes directly to RUN (FILL unused). The first offset_q outputs SHALL be 0.
  - Undefined: the CLEAR state and its address counter SHALL NOT exist, and REQ-014/015 behaviour SHALL apply.

Structure
REQ-025 Package sample_delay_buf_pkg SHALL hold the state enum typedef and the default AW/DW localparams.
REQ-026 Sub-module sdb_ram SHALL implement the storage: 2**AW x DW, one write port, one read port with registered output.
REQ-027 The FSM, pointers, bypass and output registers SHALL reside in sample_delay_buf.

Verification
All scenarios use AW=4, DW=8, in_valid=1 continuously, and in_data = 1, 2, 3, ... on successive accepts.
REQ-028 Basic delay: offset=3, en=1.
  - out_valid SHALL first go high the cycle after the 4th accept, with out_data=1.
  - Subsequent out_data SHALL be 2, 3, ...; filled SHALL rise on the 3rd accept edge.
REQ-029 Zero offset: offset=0.
  - Every accept SHALL give out_data equal to that accept's in_data one cycle later, starting with the first accept.
REQ-030 Wrap: offset=15, 20 accepts.
  - Outputs SHALL be 1..5 on accepts 16..20; wr_ptr SHALL wrap 15->0 without a glitch on out_valid.
REQ-031 Abort: offset=5, en dropped after 2 accepts.
  - The next cycle SHALL show IDLE with in_ready=0 and out_valid=0.
  - Re-enabling with offset=2 SHALL give the first output 1, from the new data, after the 3rd new accept.
REQ-032 Reset mid-RUN: rst pulsed asynchronously between edges.
  - All outputs SHALL read 0 before the next edge, and the FSM SHALL restart from IDLE.
REQ-033 Clear (with SAMPLE_DELAY_BUF_CLEAR_EN defined): offset=3.
  - in_ready SHALL be 0 for 16 cycles.
  - The first 3 outputs SHALL be 0, followed by 1, 2, 3.
